// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Brief    : MEM-stage data-memory access controller. Issues a req/ready
//            handshake with byte enables and lane-replicated store data,
//            right-aligns returned load data, stalls the pipeline until the
//            access completes, and aborts with bus_err on timeout.
//            Optional feature macro: MISALIGN_TRAP_EN (trap misaligned
//            accesses instead of forcing natural alignment).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        flush,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [1:0]  store_sel,
  input  logic [2:0]  load_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] Read_data_from_dmem,
  output logic [2:0]  load_sel_out,
  output logic        stall,
  output logic        mem_done,
  output logic        bus_err,
  output logic        misalign_exc
);

  // Counter is wide enough to hold TIMEOUT_CYCLES+1 without wrapping.
  localparam int            CW        = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] c_TIMEOUT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT_RD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [2:0]    r_load_sel;
  logic [1:0]    r_off;
  logic [31:0]   r_rdata;
  logic [2:0]    r_load_sel_out;
  logic          r_bus_err;

  logic [1:0]    w_size;      // 0 byte, 1 half, 2 word
  logic [1:0]    w_off;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_misaligned;
  logic          w_access;
  logic          w_start;
  logic [CW-1:0] w_cnt_next;
  logic          w_timeout;

  // Access size: loads take it from load_sel, stores from store_sel.
  always_comb begin
    w_size = 2'd0;
    if (mem_read) begin
      w_size = load_sel[2] ? 2'd2 : (load_sel[0] ? 2'd1 : 2'd0);
    end else begin
      w_size = store_sel[1] ? 2'd2 : (store_sel[0] ? 2'd1 : 2'd0);
    end
  end

  // Lane offset, byte enables and replicated write data; half/word offsets
  // are forced to natural alignment (trapped accesses never issue anyway).
  always_comb begin
    w_off   = addr[1:0];
    w_be    = 4'b0001 << addr[1:0];
    w_wdata = {4{store_data[7:0]}};
    case (w_size)
      2'd1: begin
        w_off   = {addr[1], 1'b0};
        w_be    = 4'b0011 << {addr[1], 1'b0};
        w_wdata = {2{store_data[15:0]}};
      end
      2'd2: begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = store_data;
      end
      default: ;
    endcase
  end

  assign w_access = (mem_read | mem_write) & ~flush;

`ifdef MISALIGN_TRAP_EN
  assign w_misaligned = ((w_size == 2'd1) & addr[0]) | ((w_size == 2'd2) & (addr[1:0] != 2'b00));
  assign misalign_exc = rst_n & (r_state == S_IDLE) & w_access & w_misaligned;
`else
  assign w_misaligned = 1'b0;
  assign misalign_exc = 1'b0;
`endif

  assign w_start    = (r_state == S_IDLE) & w_access & ~w_misaligned;
  assign w_cnt_next = r_cnt + 1'b1;
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_next >= c_TIMEOUT);

  // Stall upstream while an access is starting or outstanding; never in reset.
  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE:           stall = w_start;
        S_REQ, S_WAIT_RD: stall = 1'b1;
        default:          stall = 1'b0;
      endcase
    end
  end

  // Request is withdrawn combinationally on flush so a killed access can
  // never be accepted in the same cycle.
  assign dmem_req            = rst_n & (r_state == S_REQ) & ~flush;
  assign dmem_we             = r_we;
  assign dmem_addr           = {r_addr[31:2], 2'b00};
  assign dmem_be             = r_be;
  assign dmem_wdata          = r_wdata;
  assign Read_data_from_dmem = r_rdata;
  assign load_sel_out        = r_load_sel_out;
  assign mem_done            = (r_state == S_DONE);
  assign bus_err             = r_bus_err;

  // Access FSM: capture the request, handshake, collect read data or time out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_be           <= '0;
      r_wdata        <= '0;
      r_load_sel     <= '0;
      r_off          <= '0;
      r_rdata        <= '0;
      r_load_sel_out <= '0;
      r_bus_err      <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_we       <= mem_write;
            r_addr     <= addr;
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            r_load_sel <= load_sel;
            r_off      <= w_off;
            r_cnt      <= '0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          r_cnt <= w_cnt_next;
          if (flush) begin
            r_state <= S_IDLE;
          end else if (dmem_ready) begin
            r_state <= r_we ? S_DONE : S_WAIT_RD;
          end else if (w_timeout) begin
            r_state   <= S_DONE;
            r_bus_err <= 1'b1;
            if (!r_we) begin
              r_rdata        <= '0;
              r_load_sel_out <= r_load_sel;
            end
          end
        end
        S_WAIT_RD: begin
          r_cnt <= w_cnt_next;
          if (dmem_rvalid) begin
            r_rdata        <= dmem_rdata >> {r_off, 3'b000};
            r_load_sel_out <= r_load_sel;
            r_state        <= S_DONE;
          end else if (w_timeout) begin
            r_rdata        <= '0;
            r_load_sel_out <= r_load_sel;
            r_bus_err      <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Brief    : Self-checking bench for dmem_access_ctrl: vector table of full
//            accesses plus directed reset, flush, timeout and alignment cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mem_read, mem_write, flush;
  logic [31:0] addr, store_data;
  logic [1:0]  store_sel;
  logic [2:0]  load_sel;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;

  logic        dmem_req, dmem_we, stall, mem_done, bus_err, misalign_exc;
  logic [31:0] dmem_addr, dmem_wdata, read_data;
  logic [3:0]  dmem_be;
  logic [2:0]  lso;

  logic        to_req, to_we, to_stall, to_done, to_bus_err, to_misalign;
  logic [31:0] to_addr, to_wdata, to_read;
  logic [3:0]  to_be;
  logic [2:0]  to_lso;

  dmem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .flush(flush),
    .addr(addr), .store_data(store_data), .store_sel(store_sel), .load_sel(load_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .Read_data_from_dmem(read_data), .load_sel_out(lso),
    .stall(stall), .mem_done(mem_done), .bus_err(bus_err), .misalign_exc(misalign_exc)
  );

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .flush(flush),
    .addr(addr), .store_data(store_data), .store_sel(store_sel), .load_sel(load_sel),
    .dmem_req(to_req), .dmem_we(to_we), .dmem_addr(to_addr), .dmem_be(to_be),
    .dmem_wdata(to_wdata), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .Read_data_from_dmem(to_read), .load_sel_out(to_lso),
    .stall(to_stall), .mem_done(to_done), .bus_err(to_bus_err), .misalign_exc(to_misalign)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] sd;
    logic [1:0]  ss;
    logic [2:0]  ls;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_read;
    logic [2:0]  e_lso;
    int          e_stall;
  } vec_t;

  vec_t vecs[8];

  // One full access: inputs held until mem_done, ready after ready_delay
  // request cycles, rvalid in the cycle after acceptance.
  task automatic do_access(input vec_t v, input int ready_delay,
                           output int stall_cnt, output int done_cyc,
                           output logic [31:0] s_addr, output logic [3:0] s_be,
                           output logic [31:0] s_wdata, output logic s_we,
                           output logic stable);
    int   req_cnt;
    logic acc;
    stall_cnt = 0; done_cyc = 0; req_cnt = 0; acc = 1'b0; stable = 1'b1;
    s_addr = '0; s_be = '0; s_wdata = '0; s_we = 1'b0;
    @(posedge clk); #1;
    mem_read = v.rd; mem_write = v.wr; addr = v.a; store_data = v.sd;
    store_sel = v.ss; load_sel = v.ls; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      dmem_ready  = 1'b0;
      dmem_rvalid = 1'b0;
      if (acc) begin
        acc = 1'b0;
        if (v.rd) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = v.rdata;
        end
      end
      if (stall) stall_cnt++;
      if (mem_done) done_cyc = cyc;
      if (dmem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          s_addr = dmem_addr; s_be = dmem_be; s_wdata = dmem_wdata; s_we = dmem_we;
        end else if (dmem_addr !== s_addr || dmem_be !== s_be ||
                     dmem_wdata !== s_wdata || dmem_we !== s_we) begin
          stable = 1'b0;
        end
        if (req_cnt > ready_delay) begin
          dmem_ready = 1'b1;
          acc = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
  endtask

  initial begin
    int          sc, dc, to_dc, nd;
    logic [31:0] sa, swd;
    logic [3:0]  sb;
    logic        swe, stb, terr;
    vec_t        v;

    // inputs: rd wr addr sd ss ls rdata | addr be wdata read lso stall
    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 3'b100, 32'hDEADBEEF,
                32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 3'b100, 3};
    vecs[1] = '{1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 3'b000, 32'h80112233,
                32'h100, 4'b1000, 32'h0, 32'h00000080, 3'b000, 3};
    vecs[2] = '{1'b1, 1'b0, 32'h102, 32'h0, 2'b00, 3'b011, 32'hCAFE1234,
                32'h100, 4'b1100, 32'h0, 32'h0000CAFE, 3'b011, 3};
    vecs[3] = '{1'b1, 1'b0, 32'h101, 32'h0, 2'b00, 3'b010, 32'h11223344,
                32'h100, 4'b0010, 32'h0, 32'h00112233, 3'b010, 3};
    vecs[4] = '{1'b0, 1'b1, 32'h106, 32'h00001234, 2'b01, 3'b000, 32'h0,
                32'h104, 4'b1100, 32'h12341234, 32'h00112233, 3'b010, 2};
    vecs[5] = '{1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 2'b10, 3'b000, 32'h0,
                32'h200, 4'b1111, 32'hCAFEF00D, 32'h00112233, 3'b010, 2};
    vecs[6] = '{1'b0, 1'b1, 32'h201, 32'h1234565A, 2'b00, 3'b000, 32'h0,
                32'h200, 4'b0010, 32'h5A5A5A5A, 32'h00112233, 3'b010, 2};
    vecs[7] = '{1'b0, 1'b1, 32'h300, 32'h01020304, 2'b11, 3'b000, 32'h0,
                32'h300, 4'b1111, 32'h01020304, 32'h00112233, 3'b010, 2};

    // Reset with a load presented: stall must stay low.
    rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; flush = 1'b0;
    addr = 32'h100; store_data = '0; store_sel = '0; load_sel = 3'b100;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("stall_in_reset", stall, 0);
    check("req_in_reset", dmem_req, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    check("rst_done", mem_done, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_read_data", read_data, 0);
    check("rst_lso", lso, 0);
    check("rst_be", dmem_be, 0);
    check("rst_misalign", misalign_exc, 0);

    // rvalid while idle must be ignored.
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("idle_rvalid_ignored", read_data, 0);

    // Vector table: ready immediately, rvalid one cycle after acceptance.
    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i], 0, sc, dc, sa, sb, swd, swe, stb);
      check($sformatf("v%0d_addr", i), sa, vecs[i].e_addr);
      check($sformatf("v%0d_be", i), sb, vecs[i].e_be);
      check($sformatf("v%0d_we", i), swe, vecs[i].wr);
      if (vecs[i].wr) check($sformatf("v%0d_wdata", i), swd, vecs[i].e_wdata);
      check($sformatf("v%0d_stall", i), sc, vecs[i].e_stall);
      check($sformatf("v%0d_done_cycle", i), dc, vecs[i].e_stall + 1);
      check($sformatf("v%0d_read", i), read_data, vecs[i].e_read);
      check($sformatf("v%0d_lso", i), lso, vecs[i].e_lso);
    end

    // SB 0x102 with ready held low for three request cycles.
    v = '{1'b0, 1'b1, 32'h102, 32'h000000A5, 2'b00, 3'b000, 32'h0,
          32'h100, 4'b0100, 32'hA5A5A5A5, 32'h0, 3'b000, 5};
    do_access(v, 3, sc, dc, sa, sb, swd, swe, stb);
    check("sb_wait_addr", sa, 32'h100);
    check("sb_wait_be", sb, 4'b0100);
    check("sb_wait_wdata", swd, 32'hA5A5A5A5);
    check("sb_wait_stable", stb, 1);
    check("sb_wait_stall", sc, 5);
    check("sb_wait_done_cycle", dc, 6);

    // Misaligned LW 0x102.
`ifdef MISALIGN_TRAP_EN
    @(posedge clk); #1;
    mem_read = 1'b1; addr = 32'h102; load_sel = 3'b100;
    @(negedge clk);
    check("mis_exc", misalign_exc, 1);
    check("mis_stall", stall, 0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    check("mis_no_req", dmem_req, 0);
    check("mis_exc_pulse", misalign_exc, 0);
`else
    v = '{1'b1, 1'b0, 32'h102, 32'h0, 2'b00, 3'b100, 32'h01234567,
          32'h100, 4'b1111, 32'h0, 32'h01234567, 3'b100, 3};
    do_access(v, 0, sc, dc, sa, sb, swd, swe, stb);
    check("mis_addr", sa, 32'h100);
    check("mis_be", sb, 4'b1111);
    check("mis_read", read_data, 32'h01234567);
    check("mis_exc_tied", misalign_exc, 0);
`endif

    // Flush while the request is pending: request withdrawn, no completion.
    @(posedge clk); #1;
    mem_write = 1'b1; addr = 32'h40; store_sel = 2'b10; store_data = 32'hFFFF0000;
    @(negedge clk);
    @(negedge clk);
    check("flush_req_before", dmem_req, 1);
    @(posedge clk); #1;
    flush = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    check("flush_req_dropped", dmem_req, 0);
    @(posedge clk); #1;
    flush = 1'b0; mem_write = 1'b0; dmem_ready = 1'b0;
    nd = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_done || stall || dmem_req) nd++;
    end
    check("flush_quiet", nd, 0);

    // Timeout instance: first a good load so its read data is nonzero.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_access(vecs[0], 0, sc, dc, sa, sb, swd, swe, stb);
    check("to_pre_read", to_read, 32'hDEADBEEF);
    @(posedge clk); #1;
    mem_read = 1'b1; addr = 32'h100; load_sel = 3'b100;
    to_dc = 0; terr = 1'b0;
    for (int cyc = 1; cyc <= 12 && to_dc == 0; cyc++) begin
      @(negedge clk);
      dmem_ready = to_req;
      if (to_done) begin
        to_dc = cyc;
        terr  = to_bus_err;
      end
    end
    check("to_done_cycle", to_dc, 6);
    check("to_bus_err", terr, 1);
    check("to_read_zero", to_read, 0);
    @(posedge clk); #1;
    mem_read = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    check("to_err_pulse", to_bus_err, 0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("to_late_rvalid", to_read, 0);
    check("to_late_done", to_done, 0);
    repeat (2) @(posedge clk);

    // Reset while waiting for read data.
    #1;
    mem_read = 1'b1; addr = 32'h100; load_sel = 3'b100; dmem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    check("rstmid_stall", stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    check("rstmid_req", dmem_req, 0);
    check("rstmid_read", read_data, 0);
    check("rstmid_be", dmem_be, 0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("rstmid_discard", read_data, 0);
    check("rstmid_no_done", mem_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
